controller: RTL and testbench
=============================

# controller

Multicycle RV32I-subset control unit that sequences the shared multicycle datapath. It takes the latched instruction and the ALU zero flag from the datapath and drives every datapath enable and mux select. Control is a Moore state machine plus combinational instruction, immediate and ALU decoders. Supported instructions: lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal.

## Interface

Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH.
- Instr  in  32  latched instruction from the datapath. Fields used: op = Instr[6:0], funct3 = Instr[14:12], funct7b5 = Instr[30].
- zero  in  1  ALU result-equals-zero flag from the datapath.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- ALUSrcB  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.

## Operation

- Outputs are combinational from the state (Moore). The exceptions are PCWrite (depends on zero), ImmSrc (depends on op) and ALUControl (depends on Instr fields). Any output not listed for a state is 0.
- Internal signals:
  - ALUOp (2 bits), PCUpdate and Branch are set per state.
  - PCWrite = PCUpdate | (Branch & zero).
- States and their outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10... no: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH, with no writes (the instruction is ignored).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op = 0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- ImmSrc decode by op:
  - lw, I-type → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - otherwise → 00
- ALU decoder:
  - ALUOp 00 → 000 (add).
  - ALUOp 01 → 001 (sub).
  - ALUOp 10, decoded by funct3:
    - 000 → 001 if (funct7b5 & op[5]), else 000. This makes addi always add, including when imm[10] = 1.
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - any other funct3 → 000
  - ALUOp 11 → 000.
- State encoding is implementation choice. Unreachable encodings must return to FETCH on the next edge.

## Timing

- Reset:
  - Asserting reset forces state FETCH immediately, without waiting for a clock edge, including mid-instruction.
  - While reset is held, outputs show FETCH values. The datapath is also held in reset, so no architectural write occurs.
  - First fetch happens on the first rising edge after deassertion.
- Cycles per instruction, counted from FETCH through the last state:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - jal: 4
  - beq: 3
  - unsupported opcode: 2
- Instr is stable from the edge that ends FETCH until the next FETCH. Decoding in DECODE and later states uses that value.
- zero is sampled combinationally in BEQ only. PCWrite pulses for exactly one cycle when taken and stays 0 when not taken.
- MemWrite and RegWrite are asserted for exactly one cycle per instruction. IRWrite is asserted only in FETCH.

## Test plan

- Reset mid-MEMREAD (lw in flight), then release: state returns to FETCH asynchronously. Outputs read IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10. No RegWrite pulse follows.
- lw, Instr = 0x00412283: sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. Checks:
  - ImmSrc = 00.
  - AdrSrc = 1 in MEMREAD.
  - RegWrite = 1 with ResultSrc = 01 in cycle 5 only.
- sub, Instr = 0x40628233: ALUControl = 001 in EXECUTER. Then add, Instr = 0x00628233: ALUControl = 000. Then addi with imm[10] set, Instr = 0x40020213: ALUControl = 000. Each completes in 4 cycles.
- beq, Instr = 0x00520463:
  - with zero = 1: PCWrite = 1 in the third cycle.
  - with zero = 0: PCWrite = 0.
  - In both cases ImmSrc = 10, no RegWrite or MemWrite, and the next cycle is FETCH.
- jal then sw:
  - jal: PCWrite = 1 in the JAL state, RegWrite = 1 in ALUWB, ImmSrc = 11.
  - sw: MemWrite = 1 in exactly cycle 4, ImmSrc = 01.
- Unsupported opcode 0x0000007F: DECODE → FETCH. All write enables other than FETCH's stay 0, and the total length is 2 cycles.

Source files
------------

// File: rtl/controller.sv
// controller: multicycle RV32I-subset control unit.
// Moore FSM sequencing the shared datapath (lw, sw, R-type, I-type ALU, beq,
// jal), plus combinational immediate-format and ALU decoders.
module controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic        zero,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl
);

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BEQ,
      JAL
   } state_t;

   typedef struct packed {
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       pcupdate;
      logic       branch;
   } ctrl_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   // State-driven control word; fields not listed for a state stay 0.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irwrite   = 1'b1;
            c.alusrcb   = 2'b10;
            c.resultsrc = 2'b10;
            c.pcupdate  = 1'b1;
         end
         DECODE: begin
            c.alusrca = 2'b01;
            c.alusrcb = 2'b01;
         end
         MEMADR: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
         end
         MEMREAD: begin
            c.adrsrc = 1'b1;
         end
         MEMWB: begin
            c.resultsrc = 2'b01;
            c.regwrite  = 1'b1;
         end
         MEMWRITE: begin
            c.adrsrc   = 1'b1;
            c.memwrite = 1'b1;
         end
         EXECUTER: begin
            c.alusrca = 2'b10;
            c.aluop   = 2'b10;
         end
         EXECUTEI: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
            c.aluop   = 2'b10;
         end
         ALUWB: begin
            c.regwrite = 1'b1;
         end
         JAL: begin
            c.alusrca  = 2'b01;
            c.alusrcb  = 2'b10;
            c.pcupdate = 1'b1;
         end
         BEQ: begin
            c.alusrca = 2'b10;
            c.aluop   = 2'b01;
            c.branch  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t      state;
   state_t      state_n;
   ctrl_t       ctrl;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        unused_instr;

   assign op           = Instr[6:0];
   assign funct3       = Instr[14:12];
   assign funct7b5     = Instr[30];
   assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

   // Next-state sequencing; unknown opcodes and unreachable encodings go to FETCH.
   always_comb begin
      state_n = FETCH;
      case (state)
         FETCH:    state_n = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_n = MEMADR;
               OP_R:         state_n = EXECUTER;
               OP_I:         state_n = EXECUTEI;
               OP_BEQ:       state_n = BEQ;
               OP_JAL:       state_n = JAL;
               default:      state_n = FETCH;
            endcase
         end
         MEMADR:   state_n = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  state_n = MEMWB;
         MEMWB:    state_n = FETCH;
         MEMWRITE: state_n = FETCH;
         EXECUTER: state_n = ALUWB;
         EXECUTEI: state_n = ALUWB;
         ALUWB:    state_n = FETCH;
         JAL:      state_n = ALUWB;
         BEQ:      state_n = FETCH;
         default:  state_n = FETCH;
      endcase
   end

   // State register with the control word registered alongside it; the word is
   // computed from the next state so it always matches the current state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         ctrl  <= ctrl_of(FETCH);
      end else begin
         state <= state_n;
         ctrl  <= ctrl_of(state_n);
      end
   end

   // Drive datapath controls from the registered word; PCWrite sees zero live.
   always_comb begin
      AdrSrc    = ctrl.adrsrc;
      MemWrite  = ctrl.memwrite;
      IRWrite   = ctrl.irwrite;
      RegWrite  = ctrl.regwrite;
      ResultSrc = ctrl.resultsrc;
      ALUSrcA   = ctrl.alusrca;
      ALUSrcB   = ctrl.alusrcb;
      PCWrite   = ctrl.pcupdate | (ctrl.branch & zero);
   end

   // Immediate format decoder.
   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_LW, OP_I: ImmSrc = 2'b00;
         OP_SW:       ImmSrc = 2'b01;
         OP_BEQ:      ImmSrc = 2'b10;
         OP_JAL:      ImmSrc = 2'b11;
         default:     ImmSrc = 2'b00;
      endcase
   end

   // ALU decoder; subtract on funct3=000 only for R-type so addi always adds.
   always_comb begin
      ALUControl = 3'b000;
      case (ctrl.aluop)
         2'b00: ALUControl = 3'b000;
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_controller.sv
// tb_controller: directed and randomized instruction streams for controller,
// checked cycle by cycle against a per-instruction behavioural model.
module tb_controller;

   logic        clk;
   logic        reset;
   logic [31:0] Instr;
   logic        zero;
   logic        PCWrite;
   logic        AdrSrc;
   logic        MemWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic [1:0]  ResultSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ImmSrc;
   logic [2:0]  ALUControl;

   int checks;
   int errors;

   controller dut (
      .clk(clk),
      .reset(reset),
      .Instr(Instr),
      .zero(zero),
      .PCWrite(PCWrite),
      .AdrSrc(AdrSrc),
      .MemWrite(MemWrite),
      .IRWrite(IRWrite),
      .RegWrite(RegWrite),
      .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc),
      .ALUControl(ALUControl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed outputs packed as
   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
   function automatic logic [15:0] obs_vec();
      return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
              ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
   endfunction

   // Instruction length in cycles from FETCH to its last cycle.
   function automatic int ncyc(input logic [31:0] i);
      case (i[6:0])
         7'b0000011: return 5;
         7'b0100011: return 4;
         7'b0110011: return 4;
         7'b0010011: return 4;
         7'b1101111: return 4;
         7'b1100011: return 3;
         default:    return 2;
      endcase
   endfunction

   function automatic logic [1:0] exp_imm(input logic [31:0] i);
      case (i[6:0])
         7'b0000011, 7'b0010011: return 2'd0;
         7'b0100011:             return 2'd1;
         7'b1100011:             return 2'd2;
         7'b1101111:             return 2'd3;
         default:                return 2'd0;
      endcase
   endfunction

   // ALU operation for the execute cycle of R-type and I-type instructions.
   function automatic logic [2:0] exp_alu(input logic [31:0] i);
      case (i[14:12])
         3'b000:  return (i[30] && i[6:0] == 7'b0110011) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected outputs in cycle k of instruction i (k = 0 is the fetch cycle).
   function automatic logic [15:0] exp_vec(input logic [31:0] i, input int k, input logic z);
      logic pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb;
      logic [2:0] alu;
      logic [6:0] op;
      op = i[6:0];
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
      rs = 0; sa = 0; sb = 0; alu = 0;
      if (k == 0) begin
         irw = 1; pcw = 1; sb = 2'd2; rs = 2'd2;
      end else if (k == 1) begin
         sa = 2'd1; sb = 2'd1;
      end else begin
         case (op)
            7'b0000011: begin
               if (k == 2) begin sa = 2'd2; sb = 2'd1; end
               else if (k == 3) adr = 1;
               else begin rs = 2'd1; rw = 1; end
            end
            7'b0100011: begin
               if (k == 2) begin sa = 2'd2; sb = 2'd1; end
               else begin adr = 1; mw = 1; end
            end
            7'b0110011: begin
               if (k == 2) begin sa = 2'd2; sb = 2'd0; alu = exp_alu(i); end
               else rw = 1;
            end
            7'b0010011: begin
               if (k == 2) begin sa = 2'd2; sb = 2'd1; alu = exp_alu(i); end
               else rw = 1;
            end
            7'b1101111: begin
               if (k == 2) begin sa = 2'd1; sb = 2'd2; pcw = 1; end
               else rw = 1;
            end
            7'b1100011: begin
               sa = 2'd2; sb = 2'd0; alu = 3'b001; pcw = z;
            end
            default: ;
         endcase
      end
      return {pcw, adr, mw, irw, rw, rs, sa, sb, exp_imm(i), alu};
   endfunction

   task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Run one instruction from its fetch cycle. zmode: 0 random zero, 1 zero=1, 2 zero=0.
   task automatic run_instr(input logic [31:0] i, input int zmode, input int ncheck);
      int n;
      n = (ncheck > 0) ? ncheck : ncyc(i);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == 0) Instr = i;
         zero = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 1);
         #1 chk($sformatf("instr%08h_c%0d", i, k), obs_vec(), exp_vec(i, k, zero));
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [6:0]  op;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      Instr  = 32'h0000_0013;
      zero   = 1'b0;

      // Held in reset: fetch values.
      #3 chk("reset_hold", obs_vec(), exp_vec(Instr, 0, zero));
      @(posedge clk);
      #2 reset = 1'b0;

      // Start lw, interrupt it in MEMREAD with an asynchronous reset.
      run_instr(32'h00412283, 1, 4);
      #2 reset = 1'b1;
      #1 chk("reset_async_memread", obs_vec(), exp_vec(Instr, 0, zero));
      @(posedge clk);
      #1 chk("reset_after_edge", obs_vec(), exp_vec(Instr, 0, zero));
      #1 reset = 1'b0;

      // Directed instructions.
      run_instr(32'h00412283, 0, 0);   // lw
      run_instr(32'h40628233, 0, 0);   // sub
      run_instr(32'h00628233, 0, 0);   // add
      run_instr(32'h40020213, 0, 0);   // addi with imm[10] set
      run_instr(32'h00520463, 1, 0);   // beq taken
      run_instr(32'h00520463, 2, 0);   // beq not taken
      run_instr(32'h008000EF, 0, 0);   // jal
      run_instr(32'h00512223, 0, 0);   // sw
      run_instr(32'h0000007F, 0, 0);   // unsupported
      run_instr(32'h0062F233, 0, 0);   // and
      run_instr(32'h0062E233, 0, 0);   // or
      run_instr(32'h0062A233, 0, 0);   // slt
      run_instr(32'h00726213, 0, 0);   // ori
      run_instr(32'h00727213, 0, 0);   // andi
      run_instr(32'h00722213, 0, 0);   // slti

      // Randomized instruction stream.
      for (int n = 0; n < 300; n++) begin
         r = $urandom;
         case ($urandom_range(0, 6))
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            default: op = 7'($urandom_range(0, 127));
         endcase
         run_instr({r[31:7], op}, 0, 0);
      end

      // Final return to fetch.
      run_instr(32'h0000007F, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
